// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
// Shared types and defaults for the push-button conditioner.
//   rep_state_t         : per-channel auto-repeat FSM state
//   DEF_DEBOUNCE_CYCLES : stable synchronized samples needed to accept a change
//   DEF_REPEAT_DELAY    : cycles from a press pulse to the first repeat pulse
//   DEF_REPEAT_PERIOD   : cycles between subsequent repeat pulses
//   cnt_width()         : counter width able to hold max_val-1 (at least 1 bit)
// ----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rep_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_REPEAT_DELAY    = 500000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 100000;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One button channel: 2-flop synchronizer, counting debouncer, registered
// press pulse on a stable rising level, and an auto-repeat FSM.
//   i_clk       : clock
//   i_rst       : asynchronous active-high reset
//   i_raw       : unsynchronized bouncing button
//   i_repeat_en : auto-repeat enable, sampled every cycle
//   i_suppress  : forces the repeat FSM idle (both buttons held)
//   o_pulse     : one-cycle press / repeat pulse
//   o_level     : debounced level
// ----------------------------------------------------------------------------
module debounce_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    input  logic i_repeat_en,
    input  logic i_suppress,
    output logic o_pulse,
    output logic o_level
);

    localparam int unsigned DbW    = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned RpW    = cnt_width(RptMax);

    localparam logic [DbW-1:0] DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RpW-1:0] DelayLast  = RpW'(REPEAT_DELAY - 1);
    localparam logic [RpW-1:0] PeriodLast = RpW'(REPEAT_PERIOD - 1);

    logic           r_sync1;
    logic           r_sync2;
    logic           r_stable;
    logic           r_press;
    logic [DbW-1:0] r_db_cnt;
    rep_state_t     r_state;
    logic [RpW-1:0] r_rp_cnt;

    rep_state_t     w_state_nxt;
    logic [RpW-1:0] w_rp_cnt_nxt;
    logic           w_differs;
    logic           w_accept;
    logic           w_rep_fire;

    assign w_differs = (r_sync2 != r_stable);
    assign w_accept  = w_differs && (r_db_cnt == DbLast);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_db_cnt <= '0;
            r_state  <= StIdle;
            r_rp_cnt <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any sample matching the stable level restarts the count, so
            // the counter only ever climbs to DbLast and never wraps.
            if (!w_differs) begin
                r_db_cnt <= '0;
            end else if (w_accept) begin
                r_db_cnt <= '0;
                r_stable <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            // Press pulse lands on the same edge the stable level rises.
            r_press  <= w_accept && r_sync2;
            r_state  <= w_state_nxt;
            r_rp_cnt <= w_rp_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rp_cnt_nxt = r_rp_cnt;
        w_rep_fire   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_rp_cnt_nxt = '0;
                if (r_press) begin
                    w_state_nxt = StDelay;
                end
            end
            StDelay: begin
                if (!i_repeat_en) begin
                    w_rp_cnt_nxt = '0;
                end else if (r_rp_cnt >= DelayLast) begin
                    w_rep_fire   = 1'b1;
                    w_state_nxt  = StRepeat;
                    w_rp_cnt_nxt = '0;
                end else begin
                    w_rp_cnt_nxt = r_rp_cnt + 1'b1;
                end
            end
            StRepeat: begin
                if (!i_repeat_en) begin
                    w_rp_cnt_nxt = '0;
                end else if (r_rp_cnt >= PeriodLast) begin
                    w_rep_fire   = 1'b1;
                    w_rp_cnt_nxt = '0;
                end else begin
                    w_rp_cnt_nxt = r_rp_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = StIdle;
                w_rp_cnt_nxt = '0;
            end
        endcase
        // Released or both-held: abandon any repeat in progress.
        if (!r_stable || i_suppress) begin
            w_state_nxt  = StIdle;
            w_rp_cnt_nxt = '0;
            w_rep_fire   = 1'b0;
        end
    end

    // Press only fires from idle, repeat only from delay/repeat: never overlap.
    assign o_pulse = r_press | w_rep_fire;
    assign o_level = r_stable;

endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Conditions the clockwise / anticlockwise push-buttons into debounced levels
// and one-cycle press pulses with optional auto-repeat.
//   clk                 : clock
//   reset               : asynchronous active-high reset
//   raw_bc, raw_bac     : raw bouncing buttons
//   repeat_en           : auto-repeat enable
//   bc, bac             : one-cycle press / repeat pulses
//   bc_level, bac_level : debounced levels
// ----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_bc,
    input  logic raw_bac,
    input  logic repeat_en,
    output logic bc,
    output logic bac,
    output logic bc_level,
    output logic bac_level
);

    // Holding both buttons is not a gesture to repeat.
    logic w_both_held;
    assign w_both_held = bc_level & bac_level;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_bc (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_raw       (raw_bc),
        .i_repeat_en (repeat_en),
        .i_suppress  (w_both_held),
        .o_pulse     (bc),
        .o_level     (bc_level)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_bac (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_raw       (raw_bac),
        .i_repeat_en (repeat_en),
        .i_suppress  (w_both_held),
        .o_pulse     (bac),
        .o_level     (bac_level)
    );

endmodule
